zero_loop_counter: RTL and testbench

ZERO_LOOP_COUNTER -- requirements
Module: zero_loop_counter

---
 rtl/zero_loop_counter.sv | 83 ++++++++
 tb/tb_zero_loop_counter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/zero_loop_counter.sv
// Loadable down-counter that pulses done on the terminal decrement and never wraps below zero.
// Optional sticky underflow flag on the uflow port, compiled in with `define ZLC_UFLOW_EN.
module zero_loop_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             Z,
    output logic             busy,
    output logic             done
`ifdef ZLC_UFLOW_EN
    ,
    output logic             uflow
`endif
);

    typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
        end
    end

    // load has priority over dec; dec only acts while a loop is running
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        if (load) begin
            cnt_nxt   = load_val;
            state_nxt = (load_val != '0) ? COUNT : IDLE;
        end else if (dec && state == COUNT) begin
            if (cnt == WIDTH'(1)) begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
        end
    end

    always_comb begin
        Z    = (cnt == '0);
        busy = (state == COUNT);
    end

`ifdef ZLC_UFLOW_EN
    logic uflow_nxt;

    // sticky until the next load edge; load+dec together still clears
    always_comb begin
        uflow_nxt = uflow;
        if (load)
            uflow_nxt = 1'b0;
        else if (dec && state == IDLE)
            uflow_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            uflow <= 1'b0;
        else
            uflow <= uflow_nxt;
    end
`endif

endmodule

// File: tb/tb_zero_loop_counter.sv
// Bench for zero_loop_counter: directed vector table, reset corners, random run vs. a count model,
// and a long 16-bit run with sparse decrements.
module tb_zero_loop_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  load_val = '0;
    logic        dec = 1'b0;
    logic [7:0]  cnt;
    logic        Z, busy, done;

    logic        l16 = 1'b0;
    logic [15:0] v16 = '0;
    logic        d16 = 1'b0;
    logic [15:0] cnt16;
    logic        z16, busy16, done16;
`ifdef ZLC_UFLOW_EN
    logic        uflow, uflow16;
`endif

    always #5 clk = ~clk;

    zero_loop_counter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .dec(dec),
        .cnt(cnt), .Z(Z), .busy(busy), .done(done)
`ifdef ZLC_UFLOW_EN
        , .uflow(uflow)
`endif
    );

    zero_loop_counter #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .load(l16), .load_val(v16), .dec(d16),
        .cnt(cnt16), .Z(z16), .busy(busy16), .done(done16)
`ifdef ZLC_UFLOW_EN
        , .uflow(uflow16)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // count model: the loop value as a plain integer
    int   m_cnt = 0;
    logic m_done = 1'b0;
    logic m_uf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_done = 1'b0; m_uf = 1'b0;
    endtask

    // advance one edge, then update the model from the inputs that edge sampled
    task automatic step();
        @(posedge clk);
        #1;
        if (load) begin
            m_cnt = int'(load_val); m_done = 1'b0; m_uf = 1'b0;
        end else if (dec && m_cnt > 0) begin
            m_cnt = m_cnt - 1; m_done = (m_cnt == 0);
        end else begin
            m_done = 1'b0;
            if (dec) m_uf = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
        chk({tag, "_z"}, 32'(Z), 32'(m_cnt == 0));
        chk({tag, "_busy"}, 32'(busy), 32'(m_cnt != 0));
        chk({tag, "_done"}, 32'(done), 32'(m_done));
`ifdef ZLC_UFLOW_EN
        chk({tag, "_uflow"}, 32'(uflow), 32'(m_uf));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cnt"}, 32'(cnt), 32'h0);
        chk({tag, "_z"}, 32'(Z), 32'h1);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
`ifdef ZLC_UFLOW_EN
        chk({tag, "_uflow"}, 32'(uflow), 32'h0);
`endif
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] val;
        logic       dc;
        logic [7:0] e_cnt;
        logic       e_z;
        logic       e_busy;
        logic       e_done;
        logic       e_uf;
    } vec_t;

    vec_t vt[15];

    initial begin
        int done_at, bad;

        //          ld   val    dc   cnt    z  busy done uf
        vt[0]  = '{1'b1, 8'd3,  1'b0, 8'd3,  0, 1, 0, 0};
        vt[1]  = '{1'b0, 8'd0,  1'b1, 8'd2,  0, 1, 0, 0};
        vt[2]  = '{1'b0, 8'd0,  1'b1, 8'd1,  0, 1, 0, 0};
        vt[3]  = '{1'b0, 8'd0,  1'b1, 8'd0,  1, 0, 1, 0};
        vt[4]  = '{1'b0, 8'd0,  1'b1, 8'd0,  1, 0, 0, 1};
        vt[5]  = '{1'b1, 8'd0,  1'b0, 8'd0,  1, 0, 0, 0};
        vt[6]  = '{1'b0, 8'd0,  1'b1, 8'd0,  1, 0, 0, 1};
        vt[7]  = '{1'b1, 8'd5,  1'b0, 8'd5,  0, 1, 0, 0};
        vt[8]  = '{1'b1, 8'hFF, 1'b1, 8'hFF, 0, 1, 0, 0};
        vt[9]  = '{1'b0, 8'd0,  1'b1, 8'hFE, 0, 1, 0, 0};
        vt[10] = '{1'b1, 8'd1,  1'b0, 8'd1,  0, 1, 0, 0};
        vt[11] = '{1'b0, 8'd0,  1'b1, 8'd0,  1, 0, 1, 0};
        vt[12] = '{1'b1, 8'd2,  1'b0, 8'd2,  0, 1, 0, 0};
        vt[13] = '{1'b0, 8'd0,  1'b1, 8'd1,  0, 1, 0, 0};
        vt[14] = '{1'b1, 8'd0,  1'b1, 8'd0,  1, 0, 0, 0};

        // power-on reset
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        chk("por_cnt16", 32'(cnt16), 32'h0);
        chk("por_z16", 32'(z16), 32'h1);
        #3 rst_n = 1'b1;
        model_reset();

        // directed table
        for (int i = 0; i < 15; i++) begin
            load = vt[i].ld; load_val = vt[i].val; dec = vt[i].dc;
            step();
            chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d_z", i), 32'(Z), 32'(vt[i].e_z));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
`ifdef ZLC_UFLOW_EN
            chk($sformatf("vec%0d_uflow", i), 32'(uflow), 32'(vt[i].e_uf));
`endif
        end
        load = 1'b0; dec = 1'b0;

        // held dec from N: done exactly N edges after the load edge
        load = 1'b1; load_val = 8'd7;
        step();
        load = 1'b0; dec = 1'b1;
        done_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            check_model($sformatf("hold%0d", i));
            if (done && done_at == 0) done_at = i;
        end
        chk("hold_done_at", 32'(done_at), 32'd7);
        dec = 1'b0;

        // load 200, 100 decs, asynchronous reset mid-cycle aborts the loop
        load = 1'b1; load_val = 8'd200;
        step();
        load = 1'b0; dec = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (done) bad++;
        end
        chk("abort_no_done", 32'(bad), 32'd0);
        chk("abort_cnt100", 32'(cnt), 32'd100);
        #3 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        step();
        check_reset_vals("rst_held");
        // load sampled on the first edge after release is honoured
        load = 1'b1; load_val = 8'd1; dec = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        step();
        check_model("post_rst_load");
        load = 1'b0; dec = 1'b1;
        step();
        check_model("post_rst_done");
        chk("post_rst_done_hi", 32'(done), 32'h1);
        dec = 1'b0;
        step();
        check_model("post_rst_done_lo");

        // random run against the model
        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 15) == 0);
            load_val = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6)) : 8'($urandom);
            dec = ($urandom_range(0, 3) != 0);
            step();
            check_model($sformatf("rnd%0d", i));
        end
        load = 1'b0; dec = 1'b0;

        // 16-bit: 0x8000 decrements at half rate, no wrap
        l16 = 1'b1; v16 = 16'h8000;
        @(posedge clk); #1;
        l16 = 1'b0;
        chk("w16_load", 32'(cnt16), 32'h8000);
        chk("w16_busy", 32'(busy16), 32'h1);
        bad = 0; done_at = 0;
        for (int i = 1; i <= 32768; i++) begin
            d16 = 1'b1;
            @(posedge clk); #1;
            d16 = 1'b0;
            if (cnt16 != 16'(32768 - i)) bad++;
            if (done16) done_at = i;
            @(posedge clk); #1;
            if (done16) bad++;
        end
        chk("w16_track", 32'(bad), 32'd0);
        chk("w16_done_at", 32'(done_at), 32'd32768);
        chk("w16_idle", 32'(busy16), 32'h0);
        d16 = 1'b1;
        @(posedge clk); #1;
        d16 = 1'b0;
        chk("w16_nowrap", 32'(cnt16), 32'h0);
        chk("w16_nodone", 32'(done16), 32'h0);
`ifdef ZLC_UFLOW_EN
        chk("w16_uflow", 32'(uflow16), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
